node_burst_arbiter: RTL and testbench
=====================================

# node_burst_arbiter

Shares the single `small_buffer_ctrl` line input between two line-stream requesters, for example two DMA read channels. Arbitration is node-granular. A grant covers exactly one node: `num_of_line_per_node_minusone+1` accepted 256-bit lines. The winner's data, valid, ready and `mode` pass straight through to the buffer controller. Other requesters are stalled until the node completes. The block sits directly in front of `small_buffer_ctrl.interface_in/input_vld/input_ready/mode`.

## Interface
Parameters:
- `LINE_W`, 256: line width in bits.
- `CNT_W`, 11: width of the node line count.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `req0_data`, `req1_data`  in  LINE_W: requester line data.
- `req0_vld`, `req1_vld`  in  1: requester line valid.
- `req0_ready`, `req1_ready`  out  1: requester line accepted.
- `req0_mode`, `req1_mode`  in  2: requester mode, sampled at grant.
- `num_of_line_per_node_minusone`  in  CNT_W: lines per node minus one, sampled at grant.
- `interface_in`  out  LINE_W: line to the buffer controller.
- `input_vld`  out  1: line valid to the buffer controller.
- `input_ready`  in  1: buffer controller ready.
- `mode`  out  2: latched mode of the current owner.
- `grant`  out  2: one-hot owner; `00` means none.
- `busy`  out  1: a node is in progress.
- `node_done`  out  1: one-cycle pulse after a node's last line is accepted.
- `lines_left`  out  CNT_W: lines remaining minus one in the current node.

## Operation
- Two-state FSM: IDLE and BURST.
- IDLE:
  - If any `reqK_vld` is high, pick a winner by the priority rule.
  - Register `grant`, set `busy=1`.
  - Latch the winner's mode into `mode`.
  - Latch `num_of_line_per_node_minusone` into `lines_left`.
  - Go to BURST.
  - If no request is valid, stay in IDLE.
- BURST pass-through is combinational:
  - `interface_in = reqK_data`, `input_vld = reqK_vld`, `reqK_ready = input_ready`, all for the granted K.
  - The non-granted requester sees `ready=0`.
- A beat is accepted when `input_vld & input_ready`.
  - On each accepted beat with `lines_left != 0`, decrement `lines_left`.
  - On an accepted beat with `lines_left == 0`: next cycle `node_done=1`, `grant=00`, `busy=0`, state returns to IDLE.
- Priority rule (default round-robin):
  - `rr_ptr` resets to 0, so requester 0 is favoured.
  - When both requesters are valid in IDLE, the one selected by `rr_ptr` wins.
  - At node end, `rr_ptr` points to the requester that did not just finish.
  - A lone valid requester always wins, whatever `rr_ptr` says.
- Outside BURST:
  - `interface_in` is driven to 0 and `input_vld` to 0.
  - Both readies are 0.
- `mode` holds its last latched value until the next grant.
- Changes to `num_of_line_per_node_minusone` or to a requester's mode during BURST are ignored until the next grant.
- The granted requester may drop `vld` mid-node. The grant is held indefinitely; there is no timeout.
- Count range: `num_of_line_per_node_minusone=0` gives 1 line; 2047 gives 2048 lines. No wrap; the counter stops at 0.
- Reset mid-node: immediate return to the reset state. The partial node is abandoned and `node_done` does not pulse.

## Timing
- Reset values:
  - State IDLE.
  - `grant=00`, `busy=0`, `node_done=0`, `rr_ptr=0`.
  - `mode=00`, `lines_left=0`.
  - `input_vld=0`, `interface_in=0`, `req0_ready=req1_ready=0`.
- Request seen high in IDLE at edge t → `grant` and `busy` valid after edge t. The first line can transfer in the same cycle (cycle t+1).
- Data path latency is zero cycles: no pipeline register in the line path.
- Last line accepted in cycle c → after edge c: `node_done=1` for one cycle, `grant=00`, state IDLE.
- The earliest next grant is registered at the edge ending cycle c+1. There is exactly one bubble cycle between nodes.
- Minimum node period is N+1 cycles with continuous valid and ready.

## Configuration
- `NODE_ARB_FIXED_PRIO_EN`:
  - Defined: requester 0 always wins simultaneous requests. `rr_ptr` is removed and held at constant 0.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Single-requester node: N-1=3, `req0` streams 4 lines with `input_ready=1`.
  - Required: `grant=01`, 4 beats forwarded in order.
  - Required: `node_done` pulses the cycle after beat 4, then `grant=00`.
- Contention, round-robin: both requesters valid continuously, N-1=1.
  - Required grant order: 01, 10, 01, 10.
  - Required: exactly 2 beats per grant and one idle cycle between grants.
- Backpressure: `input_ready` toggles 1,0,1,0 during a 4-line node.
  - Required: the owner's ready mirrors `input_ready`.
  - Required: `lines_left` decrements only on accepted beats; the node completes after 4 accepts.
- Latching: `req0_mode=10` at grant. Change `req0_mode` and `num_of_line_per_node_minusone` mid-node.
  - Required: `mode` stays 10 and the line count is unchanged for the whole node.
- Boundary: N-1=0 gives a 1-line node with `node_done` next cycle. N-1=2047 gives exactly 2048 accepts before `node_done`.
- Reset mid-node: assert `rst` after 5 of 8 lines.
  - Required: all outputs return to reset values asynchronously, with no `node_done`.
  - Required: after release, the next request gets a fresh grant with a full count.
  - With `NODE_ARB_FIXED_PRIO_EN`: continuous contention gives `grant` always 01.

Source files
------------

// File: rtl/node_burst_arbiter.sv
// node_burst_arbiter
// Shares one small_buffer_ctrl line input between two line-stream requesters.
// A grant covers one whole node of (num_of_line_per_node_minusone + 1) accepted
// lines. During the node, the owner's data, valid and ready pass through
// combinationally. The other requester is stalled until the node completes.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req{0,1}_data/_vld/_ready      requester line streams
//   req{0,1}_mode                  requester mode, latched at grant
//   num_of_line_per_node_minusone  node length minus one, latched at grant
//   interface_in/input_vld         line stream to the buffer controller
//   input_ready                    buffer controller ready
//   mode                           latched mode of the current owner
//   grant                          one-hot owner, 00 = none
//   busy                           node in progress
//   node_done                      one-cycle pulse after a node's last line
//   lines_left                     lines remaining minus one in the node
//
// Configuration:
//   NODE_ARB_FIXED_PRIO_EN  defined: requester 0 always wins ties.
//                           undefined (default): round-robin between nodes.
module node_burst_arbiter #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0] req0_data,
    input  logic              req0_vld,
    output logic              req0_ready,
    input  logic [1:0]        req0_mode,
    input  logic [LINE_W-1:0] req1_data,
    input  logic              req1_vld,
    output logic              req1_ready,
    input  logic [1:0]        req1_mode,
    input  logic [CNT_W-1:0]  num_of_line_per_node_minusone,
    output logic [LINE_W-1:0] interface_in,
    output logic              input_vld,
    input  logic              input_ready,
    output logic [1:0]        mode,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              node_done,
    output logic [CNT_W-1:0]  lines_left
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t             r_state;
    logic [1:0]         r_grant;
    logic               r_busy;
    logic               r_node_done;
    logic [1:0]         r_mode;
    logic [CNT_W-1:0]   r_lines_left;

    logic               w_in_burst;
    logic               w_sel;
    logic               w_own_vld;
    logic               w_accept;
    logic               w_last_beat;
    logic               w_rr_ptr;
    logic               w_pick1;

    assign w_in_burst  = (r_state == S_BURST);
    assign w_sel       = r_grant[1];
    assign w_own_vld   = w_sel ? req1_vld : req0_vld;
    assign w_accept    = w_in_burst & w_own_vld & input_ready;
    assign w_last_beat = w_accept & (r_lines_left == '0);

`ifdef NODE_ARB_FIXED_PRIO_EN
    // Fixed priority: the pointer is constant, so requester 0 wins ties.
    assign w_rr_ptr = 1'b0;
`else
    logic r_rr_ptr;

    // Round-robin pointer: after a node, favour the requester that did not just finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_last_beat) begin
            r_rr_ptr <= ~w_sel;
        end
    end

    assign w_rr_ptr = r_rr_ptr;
`endif

    // Requester 1 wins when it is alone, or when both request and the pointer favours it.
    assign w_pick1 = req1_vld & (~req0_vld | w_rr_ptr);

    // Node FSM: grant on any request in IDLE, count accepted beats in BURST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= 2'b00;
            r_busy       <= 1'b0;
            r_node_done  <= 1'b0;
            r_mode       <= 2'b00;
            r_lines_left <= '0;
        end else begin
            r_node_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req0_vld | req1_vld) begin
                        r_state      <= S_BURST;
                        r_busy       <= 1'b1;
                        r_grant      <= w_pick1 ? 2'b10 : 2'b01;
                        r_mode       <= w_pick1 ? req1_mode : req0_mode;
                        r_lines_left <= num_of_line_per_node_minusone;
                    end
                end
                S_BURST: begin
                    if (w_accept) begin
                        if (r_lines_left != '0) begin
                            r_lines_left <= r_lines_left - CNT_W'(1);
                        end else begin
                            r_state     <= S_IDLE;
                            r_busy      <= 1'b0;
                            r_grant     <= 2'b00;
                            r_node_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Zero-latency pass-through for the owner; everything is quiet outside BURST.
    assign interface_in = w_in_burst ? (w_sel ? req1_data : req0_data) : '0;
    assign input_vld    = w_in_burst & w_own_vld;
    assign req0_ready   = w_in_burst & r_grant[0] & input_ready;
    assign req1_ready   = w_in_burst & r_grant[1] & input_ready;

    assign mode       = r_mode;
    assign grant      = r_grant;
    assign busy       = r_busy;
    assign node_done  = r_node_done;
    assign lines_left = r_lines_left;

endmodule

// File: tb/tb_node_burst_arbiter.sv
// Directed bench for node_burst_arbiter: single node, contention, backpressure,
// latching, count boundaries and reset in the middle of a node.
module tb_node_burst_arbiter;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned CNT_W  = 11;

    logic              clk;
    logic              rst;
    logic [LINE_W-1:0] req0_data;
    logic              req0_vld;
    logic              req0_ready;
    logic [1:0]        req0_mode;
    logic [LINE_W-1:0] req1_data;
    logic              req1_vld;
    logic              req1_ready;
    logic [1:0]        req1_mode;
    logic [CNT_W-1:0]  num_of_line_per_node_minusone;
    logic [LINE_W-1:0] interface_in;
    logic              input_vld;
    logic              input_ready;
    logic [1:0]        mode;
    logic [1:0]        grant;
    logic              busy;
    logic              node_done;
    logic [CNT_W-1:0]  lines_left;

    int n_checks = 0;
    int n_errors = 0;

    node_burst_arbiter #(.LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .req0_data                     (req0_data),
        .req0_vld                      (req0_vld),
        .req0_ready                    (req0_ready),
        .req0_mode                     (req0_mode),
        .req1_data                     (req1_data),
        .req1_vld                      (req1_vld),
        .req1_ready                    (req1_ready),
        .req1_mode                     (req1_mode),
        .num_of_line_per_node_minusone (num_of_line_per_node_minusone),
        .interface_in                  (interface_in),
        .input_vld                     (input_vld),
        .input_ready                   (input_ready),
        .mode                          (mode),
        .grant                         (grant),
        .busy                          (busy),
        .node_done                     (node_done),
        .lines_left                    (lines_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Distinct, recognisable line pattern per requester and beat.
    function automatic logic [LINE_W-1:0] mk(input int id, input int k);
        logic [31:0] w;
        w = {8'(id), 24'(k)};
        return {8{w}};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        input_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL reset_grant: got %b exp 00", grant); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_checks++; if (node_done !== 1'b0) begin n_errors++; $display("FAIL reset_node_done: got %b exp 0", node_done); end
        n_checks++; if (mode !== 2'b00) begin n_errors++; $display("FAIL reset_mode: got %b exp 00", mode); end
        n_checks++; if (lines_left !== '0) begin n_errors++; $display("FAIL reset_lines_left: got %0d exp 0", lines_left); end
        n_checks++; if (input_vld !== 1'b0) begin n_errors++; $display("FAIL reset_input_vld: got %b exp 0", input_vld); end
        n_checks++; if (interface_in !== '0) begin n_errors++; $display("FAIL reset_interface_in: got %h exp 0", interface_in); end
        n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b%b exp 00", req1_ready, req0_ready); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        num_of_line_per_node_minusone = 11'd3;
        input_ready = 1'b1;
        req0_data = mk(0, 0);
        req0_vld = 1'b1;
        @(negedge clk);
        n_checks++; if (grant !== 2'b01) begin n_errors++; $display("FAIL single_grant: got %b exp 01", grant); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy: got %b exp 1", busy); end
        for (int k = 0; k < 4; k++) begin
            req0_data = mk(0, k);
            #1;
            n_checks++; if (interface_in !== mk(0, k)) begin n_errors++; $display("FAIL single_data[%0d]: got %h exp %h", k, interface_in, mk(0, k)); end
            n_checks++; if (input_vld !== 1'b1 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_errors++; $display("FAIL single_hs[%0d]: got vld=%b r0=%b r1=%b exp 1 1 0", k, input_vld, req0_ready, req1_ready); end
            n_checks++; if (lines_left !== CNT_W'(3 - k)) begin n_errors++; $display("FAIL single_lines_left[%0d]: got %0d exp %0d", k, lines_left, 3 - k); end
            @(negedge clk);
        end
        n_checks++; if (node_done !== 1'b1) begin n_errors++; $display("FAIL single_node_done: got %b exp 1", node_done); end
        n_checks++; if (grant !== 2'b00 || busy !== 1'b0 || input_vld !== 1'b0) begin n_errors++; $display("FAIL single_end: got grant=%b busy=%b vld=%b exp 00 0 0", grant, busy, input_vld); end
        req0_vld = 1'b0;
        @(negedge clk);
        n_checks++; if (node_done !== 1'b0 || grant !== 2'b00) begin n_errors++; $display("FAIL single_after: got done=%b grant=%b exp 0 00", node_done, grant); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [12];
`ifdef NODE_ARB_FIXED_PRIO_EN
        exp_g = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00,
                  2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
`else
        exp_g = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                  2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
`endif
        do_reset();
        num_of_line_per_node_minusone = 11'd1;
        input_ready = 1'b1;
        req0_data = mk(0, 9);
        req1_data = mk(1, 9);
        req0_vld = 1'b1;
        req1_vld = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++; if (grant !== exp_g[i]) begin n_errors++; $display("FAIL rr_grant[%0d]: got %b exp %b", i, grant, exp_g[i]); end
            n_checks++; if (input_vld !== (exp_g[i] != 2'b00) || node_done !== (exp_g[i] == 2'b00)) begin n_errors++; $display("FAIL rr_vld_done[%0d]: got vld=%b done=%b", i, input_vld, node_done); end
            n_checks++; if (req0_ready !== exp_g[i][0] || req1_ready !== exp_g[i][1]) begin n_errors++; $display("FAIL rr_ready[%0d]: got %b%b exp %b", i, req1_ready, req0_ready, exp_g[i]); end
            if (i == 11) begin
                req0_vld = 1'b0;
                req1_vld = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        int acc;
        acc = 0;
        num_of_line_per_node_minusone = 11'd3;
        input_ready = 1'b0;
        req1_data = mk(1, 0);
        req1_vld = 1'b1;
        @(negedge clk);
        n_checks++; if (grant !== 2'b10) begin n_errors++; $display("FAIL bp_grant: got %b exp 10", grant); end
        for (int i = 0; i < 7; i++) begin
            input_ready = (i % 2 == 0);
            req1_data = mk(1, i);
            #1;
            n_checks++; if (req1_ready !== input_ready || req0_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready[%0d]: got r1=%b r0=%b exp %b 0", i, req1_ready, req0_ready, input_ready); end
            n_checks++; if (lines_left !== CNT_W'(3 - acc)) begin n_errors++; $display("FAIL bp_lines_left[%0d]: got %0d exp %0d", i, lines_left, 3 - acc); end
            n_checks++; if (node_done !== 1'b0) begin n_errors++; $display("FAIL bp_early_done[%0d]: got %b exp 0", i, node_done); end
            if (input_ready) acc++;
            @(negedge clk);
        end
        n_checks++; if (node_done !== 1'b1 || grant !== 2'b00) begin n_errors++; $display("FAIL bp_node_done: got done=%b grant=%b exp 1 00", node_done, grant); end
        req1_vld = 1'b0;
        input_ready = 1'b1;
    endtask

    task automatic test_latch();
        req0_mode = 2'b10;
        req1_mode = 2'b11;
        num_of_line_per_node_minusone = 11'd3;
        input_ready = 1'b1;
        req0_vld = 1'b1;
        @(negedge clk);
        req0_mode = 2'b01;
        num_of_line_per_node_minusone = 11'd0;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (mode !== 2'b10) begin n_errors++; $display("FAIL latch_mode[%0d]: got %b exp 10", k, mode); end
            n_checks++; if (lines_left !== CNT_W'(3 - k) || node_done !== 1'b0) begin n_errors++; $display("FAIL latch_count[%0d]: got ll=%0d done=%b exp %0d 0", k, lines_left, node_done, 3 - k); end
            @(negedge clk);
        end
        n_checks++; if (node_done !== 1'b1) begin n_errors++; $display("FAIL latch_node_done: got %b exp 1", node_done); end
        req0_vld = 1'b0;
        @(negedge clk);
        n_checks++; if (mode !== 2'b10) begin n_errors++; $display("FAIL latch_mode_hold: got %b exp 10", mode); end
    endtask

    task automatic test_boundary();
        int acc;
        bit done;
        num_of_line_per_node_minusone = 11'd0;
        input_ready = 1'b1;
        req1_vld = 1'b1;
        @(negedge clk);
        n_checks++; if (grant !== 2'b10 || lines_left !== '0) begin n_errors++; $display("FAIL bnd1_grant: got grant=%b ll=%0d exp 10 0", grant, lines_left); end
        @(negedge clk);
        n_checks++; if (node_done !== 1'b1 || grant !== 2'b00) begin n_errors++; $display("FAIL bnd1_done: got done=%b grant=%b exp 1 00", node_done, grant); end
        req1_vld = 1'b0;
        @(negedge clk);
        acc = 0;
        done = 1'b0;
        num_of_line_per_node_minusone = 11'd2047;
        req0_vld = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                n_checks++; if (lines_left !== 11'd2047) begin n_errors++; $display("FAIL bnd2048_start: got %0d exp 2047", lines_left); end
            end
            if (node_done) begin
                done = 1'b1;
                break;
            end
            if (input_vld && req0_ready) acc++;
        end
        req0_vld = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL bnd2048_timeout: node_done not seen, got %0d accepts", acc); end
        n_checks++; if (acc != 2048) begin n_errors++; $display("FAIL bnd2048_accepts: got %0d exp 2048", acc); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0_mode = 2'b01;
        num_of_line_per_node_minusone = 11'd7;
        input_ready = 1'b1;
        req0_vld = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            req0_data = mk(0, k);
            @(negedge clk);
        end
        n_checks++; if (lines_left !== 11'd2) begin n_errors++; $display("FAIL rstmid_pre: got %0d exp 2", lines_left); end
        rst = 1'b1;
        #1;
        n_checks++; if (grant !== 2'b00 || busy !== 1'b0 || node_done !== 1'b0) begin n_errors++; $display("FAIL rstmid_ctrl: got grant=%b busy=%b done=%b exp 00 0 0", grant, busy, node_done); end
        n_checks++; if (mode !== 2'b00 || lines_left !== '0) begin n_errors++; $display("FAIL rstmid_regs: got mode=%b ll=%0d exp 00 0", mode, lines_left); end
        n_checks++; if (input_vld !== 1'b0 || interface_in !== '0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_errors++; $display("FAIL rstmid_path: got vld=%b r0=%b r1=%b", input_vld, req0_ready, req1_ready); end
        @(negedge clk);
        n_checks++; if (node_done !== 1'b0) begin n_errors++; $display("FAIL rstmid_no_done: got %b exp 0", node_done); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (grant !== 2'b01 || lines_left !== 11'd7 || mode !== 2'b01) begin n_errors++; $display("FAIL rstmid_regrant: got grant=%b ll=%0d mode=%b exp 01 7 01", grant, lines_left, mode); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++; if (node_done !== (k == 7)) begin n_errors++; $display("FAIL rstmid_done[%0d]: got %b exp %b", k, node_done, (k == 7)); end
        end
        req0_vld = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req0_data = '0;
        req1_data = '0;
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        req0_mode = 2'b00;
        req1_mode = 2'b00;
        num_of_line_per_node_minusone = '0;
        input_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_latch();
        test_boundary();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
